// File: rtl/aha_axi_sram_bridge.sv
// aha_axi_sram_bridge: AXI4 slave to single-port synchronous SRAM bridge.
// FIXED/INCR/WRAP bursts, fair AW/AR arbitration, read skid FIFO.
module aha_axi_sram_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 27,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [31:0]               S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWLOCK,
  input  logic [3:0]                S_AXI_AWCACHE,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [31:0]               S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARLOCK,
  input  logic [3:0]                S_AXI_ARCACHE,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]       S_AXI_RID,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic                      SRAM_CEn,
  output logic                      SRAM_WEn,
  output logic [MEM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0]     SRAM_WDATA,
  output logic [DATA_WIDTH/8-1:0]   SRAM_WBEn,
  input  logic [DATA_WIDTH-1:0]     SRAM_RDATA
);
  localparam int LSB = $clog2(DATA_WIDTH/8);
  localparam int FD = RD_LATENCY + 2;
  localparam logic [3:0] FDEPTH = 4'(FD);
  localparam logic [2:0] PLAST = 3'(FD - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;
  localparam logic [1:0] RD_RUN  = 2'd3;
  localparam logic [1:0] FIXED   = 2'd0;
  localparam logic [1:0] INCR    = 2'd1;
  localparam logic [1:0] WRAP    = 2'd2;
  localparam logic [1:0] OKAY    = 2'd0;
  localparam logic [1:0] SLVERR  = 2'd2;

  function automatic logic berr(logic [7:0] l, logic [2:0] s,
                                logic [1:0] b);
    logic wl;
    wl = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
    return (b == 2'b11) || (b == WRAP && !wl) || (s > 3'(LSB));
  endfunction

  function automatic logic [31:0] nxt(logic [31:0] a, logic [7:0] l,
                                      logic [2:0] s, logic [1:0] b);
    logic [31:0] inc, al, win, res;
    inc = 32'd1 << s;
    al = (a & ~(inc - 32'd1)) + inc;
    win = ({24'd0, l} + 32'd1) << s;
    res = a;
    if (b == INCR) res = al;
    else if (b == WRAP) res = (a & ~(win - 32'd1)) | (al & (win - 32'd1));
    return res;
  endfunction

  logic [1:0] state;
  logic last_wr;
  logic [ID_WIDTH-1:0] id;
  logic [31:0] addr;
  logic [7:0] len;
  logic [2:0] size;
  logic [1:0] burst;
  logic err, wr_bad;
  logic [8:0] icnt;
  logic [7:0] rcnt;

  logic aw_gnt, ar_gnt, idle;
  logic [ID_WIDTH-1:0] a_id;
  logic [31:0] a_addr;
  logic [7:0] a_len;
  logic [2:0] a_size;
  logic [1:0] a_burst;

  // Both valid: the channel that lost last time wins.
  assign aw_gnt = S_AXI_AWVALID && (!S_AXI_ARVALID || !last_wr);
  assign ar_gnt = S_AXI_ARVALID && !aw_gnt;
  assign idle = state == IDLE;
  assign a_id = aw_gnt ? S_AXI_AWID : S_AXI_ARID;
  assign a_addr = aw_gnt ? S_AXI_AWADDR : S_AXI_ARADDR;
  assign a_len = aw_gnt ? S_AXI_AWLEN : S_AXI_ARLEN;
  assign a_size = aw_gnt ? S_AXI_AWSIZE : S_AXI_ARSIZE;
  assign a_burst = aw_gnt ? S_AXI_AWBURST : S_AXI_ARBURST;

  assign S_AXI_AWREADY = ARESETn && idle && aw_gnt;
  assign S_AXI_ARREADY = ARESETn && idle && ar_gnt;
  assign S_AXI_WREADY = ARESETn && state == WR_DATA;
  assign S_AXI_BVALID = state == WR_RESP;
  assign S_AXI_BID = S_AXI_BVALID ? id : '0;
  assign S_AXI_BRESP = (S_AXI_BVALID && (err || wr_bad)) ? SLVERR : OKAY;

  logic [RD_LATENCY-1:0] vld;
  logic [3:0] occ, infl;
  logic [2:0] wp, rp;
  logic [DATA_WIDTH-1:0] fifo [0:7];
  logic rd_issue, push, pop, beat_last;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LATENCY; i++) infl = infl + 4'(vld[i]);
  end

  // Only issue what the FIFO is guaranteed to absorb.
  assign rd_issue = state == RD_RUN && icnt <= {1'b0, len}
                 && (occ + infl) < FDEPTH;
  assign push = vld[RD_LATENCY-1];
  assign pop = S_AXI_RVALID && S_AXI_RREADY;
  assign S_AXI_RVALID = occ != 4'd0;
  assign S_AXI_RDATA = S_AXI_RVALID ? fifo[rp] : '0;
  assign S_AXI_RID = S_AXI_RVALID ? id : '0;
  assign S_AXI_RRESP = (S_AXI_RVALID && err) ? SLVERR : OKAY;
  assign S_AXI_RLAST = S_AXI_RVALID && rcnt == len;
  assign beat_last = icnt == {1'b0, len};

  logic wr_hs, wr_acc, rd_acc;
  assign wr_hs = S_AXI_WREADY && S_AXI_WVALID;
  assign wr_acc = wr_hs && !err;
  assign rd_acc = rd_issue && !err;
  assign SRAM_CEn = !(wr_acc || rd_acc);
  assign SRAM_WEn = !wr_acc;
  assign SRAM_WBEn = wr_acc ? ~S_AXI_WSTRB : '1;
  assign SRAM_WDATA = wr_acc ? S_AXI_WDATA : '0;
  assign SRAM_ADDR = (wr_acc || rd_acc) ? addr[LSB +: MEM_ADDR_WIDTH] : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      last_wr <= 1'b0;
      id <= '0;
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      err <= 1'b0;
      wr_bad <= 1'b0;
      icnt <= '0;
      rcnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (S_AXI_AWREADY || S_AXI_ARREADY) begin
          last_wr <= aw_gnt;
          id <= a_id;
          addr <= a_addr;
          len <= a_len;
          size <= a_size;
          burst <= a_burst;
          err <= berr(a_len, a_size, a_burst);
          wr_bad <= 1'b0;
          icnt <= '0;
          rcnt <= '0;
          state <= aw_gnt ? WR_DATA : RD_RUN;
        end
        WR_DATA: if (wr_hs) begin
          icnt <= icnt + 9'd1;
          addr <= nxt(addr, len, size, burst);
          if (S_AXI_WLAST != beat_last) wr_bad <= 1'b1;
          if (beat_last) state <= WR_RESP;
        end
        WR_RESP: if (S_AXI_BREADY) state <= IDLE;
        RD_RUN: begin
          if (rd_issue) begin
            icnt <= icnt + 9'd1;
            addr <= nxt(addr, len, size, burst);
          end
          if (pop) begin
            rcnt <= rcnt + 8'd1;
            if (S_AXI_RLAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vld <= '0;
      occ <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      vld <= (vld << 1) | RD_LATENCY'(rd_issue);
      if (push) wp <= (wp == PLAST) ? 3'd0 : wp + 3'd1;
      if (pop) rp <= (rp == PLAST) ? 3'd0 : rp + 3'd1;
      occ <= occ + 4'(push) - 4'(pop);
    end
  end

  // Error bursts still flow through the pipe so beat counts hold.
  always_ff @(posedge ACLK) begin
    if (push) fifo[wp] <= err ? '0 : SRAM_RDATA;
  end

  logic unused;
  assign unused = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                    S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT};
endmodule

// File: tb/tb_aha_axi_sram_bridge.sv
// tb_aha_axi_sram_bridge: directed vector bench for the AXI/SRAM bridge
// with a behavioural 2-cycle-latency SRAM model.
module tb_aha_axi_sram_bridge;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [3:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata;
  logic [7:0] wstrb, wben;
  logic wlast, wvalid, wready, bvalid, bready;
  logic rlast, rvalid, rready;
  logic cen, wen;
  logic [26:0] saddr;
  logic [63:0] swdata, srdata;

  aha_axi_sram_bridge #(
    .DATA_WIDTH(64), .ID_WIDTH(4), .MEM_ADDR_WIDTH(27), .RD_LATENCY(LAT)
  ) dut (
    .ACLK(clk), .ARESETn(rstn),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0),
    .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .SRAM_CEn(cen), .SRAM_WEn(wen), .SRAM_ADDR(saddr),
    .SRAM_WDATA(swdata), .SRAM_WBEn(wben), .SRAM_RDATA(srdata)
  );

  logic [63:0] mem [0:1023];
  logic [63:0] q1, q2;
  assign srdata = q2;
  always @(posedge clk) begin
    q1 <= (!cen && wen) ? mem[saddr[9:0]] : 64'hA5A5_5A5A_A5A5_5A5A;
    q2 <= q1;
    if (!cen && !wen)
      for (int b = 0; b < 8; b++)
        if (!wben[b]) mem[saddr[9:0]][b*8 +: 8] <= swdata[b*8 +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int acc_cnt = 0, rd_issues = 0, outstanding = 0, max_out = 0;
  int overlap = 0, first_rd = -1, first_rv = -1;
  logic [26:0] wr_addrs[$];

  always @(negedge clk) begin
    if (!rstn) outstanding = 0;
    else begin
      if (!cen) acc_cnt++;
      if (!cen && !wen) wr_addrs.push_back(saddr);
      if (!cen && wen) begin
        rd_issues++;
        outstanding++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (rvalid && first_rv < 0) first_rv = cyc;
      if (rvalid && rready) outstanding--;
      if (outstanding > max_out) max_out = outstanding;
      if (bvalid && rvalid) overlap++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic aw_send(input logic [3:0] i, input logic [31:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, output int t);
    awid = i; awaddr = a; awlen = l; awsize = s; awburst = b;
    awvalid = 1'b1;
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if (awready) t = cyc;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    if (t < 0) tmo("aw_handshake");
  endtask

  task automatic ar_send(input logic [3:0] i, input logic [31:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, output int t);
    arid = i; araddr = a; arlen = l; arsize = s; arburst = b;
    arvalid = 1'b1;
    first_rd = -1;
    first_rv = -1;
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if (arready) t = cyc;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (t < 0) tmo("ar_handshake");
  endtask

  task automatic w_send(input logic [7:0] l, input logic [63:0] d0,
                        input logic [7:0] st, input int lastb,
                        output int tf, output int tl);
    tf = -1;
    tl = -1;
    for (int n = 0; n <= int'(l); n++) begin
      bit got;
      got = 1'b0;
      wdata = d0 + 64'(n); wstrb = st; wlast = (n == lastb);
      wvalid = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (wready) begin
          got = 1'b1;
          if (n == 0) tf = cyc;
          tl = cyc;
        end
        @(posedge clk); #1;
      end
      if (!got) begin
        tmo("w_handshake");
        break;
      end
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] r, output logic [3:0] i,
                        output int t);
    bready = 1'b1;
    t = -1;
    r = 2'bxx;
    i = 4'hx;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if (bvalid) begin
        t = cyc; r = bresp; i = bid;
      end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (t < 0) tmo("b_handshake");
  endtask

  logic [63:0] rd_data [0:31];
  logic rd_last [0:31];
  logic [1:0] rd_resp [0:31];
  logic [3:0] rd_id [0:31];
  int nrd, rc_first, rc_last;

  task automatic r_recv(input logic [3:0] pat, input int stall);
    bit done;
    done = 1'b0;
    nrd = 0;
    rc_first = -1;
    rc_last = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      rready = (k < stall) ? 1'b0 : pat[(k - stall) % 4];
      @(negedge clk);
      if (rvalid && rready && nrd < 32) begin
        rd_data[nrd] = rdata; rd_last[nrd] = rlast;
        rd_resp[nrd] = rresp; rd_id[nrd] = rid;
        if (nrd == 0) rc_first = cyc;
        rc_last = cyc;
        nrd++;
        if (rlast) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!done) tmo("r_last");
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [63:0] d0;
    logic [7:0] strb;
    logic [3:0] pat;
    logic [1:0] resp;
    logic [63:0] exp0;
    logic [63:0] step;
  } vec_t;

  vec_t v [8];

  initial begin
    int ta, tf, tl, tb, a0, base;
    logic [1:0] br;
    logic [3:0] bi;
    int g [3];

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ta, tf, tl, tb, a0, base;
    bit e;
    logic [1:0] br;
    logic [3:0] bi;
    int g [3];

    v[0] = '{32'h100, 8'd0, 3'd3, 2'd1, 64'hDEADBEEF_CAFEF00D, 8'h0F,
             4'b1111, 2'd0, 64'h00000000_CAFEF00D, 64'd0};
    v[1] = '{32'h200, 8'd7, 3'd3, 2'd1, 64'h1000_0000_0000_0000, 8'hFF,
             4'b1001, 2'd0, 64'h1000_0000_0000_0000, 64'd1};
    v[2] = '{32'h400, 8'd0, 3'd3, 2'd1, 64'h11223344_55667788, 8'hF0,
             4'b1111, 2'd0, 64'h11223344_00000000, 64'd0};
    v[3] = '{32'h500, 8'd1, 3'd3, 2'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF,
             4'b1111, 2'd2, 64'd0, 64'd0};
    v[4] = '{32'h508, 8'd0, 3'd4, 2'd1, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF,
             4'b1111, 2'd2, 64'd0, 64'd0};
    v[5] = '{32'h510, 8'd2, 3'd3, 2'd2, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF,
             4'b1111, 2'd2, 64'd0, 64'd0};
    v[6] = '{32'h700, 8'd2, 3'd3, 2'd0, 64'h7000, 8'hFF,
             4'b1111, 2'd0, 64'h7002, 64'd0};
    v[7] = '{32'h800, 8'd3, 3'd3, 2'd2, 64'h8000, 8'hFF,
             4'b1111, 2'd0, 64'h8000, 64'd1};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0; rready = 0;
    rstn = 1'b0;
    awvalid = 1'b1;
    arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_cen", cen, 1);
    chk("rst_wen", wen, 1);
    chk("rst_wben", wben, 8'hFF);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    awvalid = 1'b0;
    arvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      e = v[i].resp != 2'd0;
      a0 = acc_cnt;
      aw_send(4'(i), v[i].addr, v[i].len, v[i].size, v[i].burst, ta);
      w_send(v[i].len, v[i].d0, v[i].strb, int'(v[i].len), tf, tl);
      chk($sformatf("v%0d_w_first_cycle", i), tf, ta + 1);
      chk($sformatf("v%0d_w_beats", i), tl - tf, int'(v[i].len));
      b_recv(br, bi, tb);
      chk($sformatf("v%0d_b_cycle", i), tb, tl + 1);
      chk($sformatf("v%0d_bresp", i), br, v[i].resp);
      chk($sformatf("v%0d_bid", i), bi, 4'(i));
      chk($sformatf("v%0d_wr_access", i), acc_cnt - a0,
          e ? 0 : int'(v[i].len) + 1);
      a0 = acc_cnt;
      ar_send(4'(i), v[i].addr, v[i].len, v[i].size, v[i].burst, ta);
      r_recv(v[i].pat, 0);
      chk($sformatf("v%0d_r_beats", i), nrd, int'(v[i].len) + 1);
      chk($sformatf("v%0d_rd_access", i), acc_cnt - a0,
          e ? 0 : int'(v[i].len) + 1);
      if (!e) begin
        chk($sformatf("v%0d_first_read", i), first_rd, ta + 1);
        chk($sformatf("v%0d_first_rvalid", i), first_rv, ta + 2 + LAT);
      end
      if (!e && v[i].pat == 4'b1111)
        chk($sformatf("v%0d_r_throughput", i), rc_last - rc_first,
            int'(v[i].len));
      for (int n = 0; n < nrd; n++) begin
        chk($sformatf("v%0d_rdata%0d", i, n), rd_data[n],
            v[i].exp0 + 64'(n) * v[i].step);
        chk($sformatf("v%0d_rlast%0d", i, n), rd_last[n],
            n == int'(v[i].len));
        chk($sformatf("v%0d_rresp%0d", i, n), rd_resp[n], v[i].resp);
        chk($sformatf("v%0d_rid%0d", i, n), rd_id[n], 4'(i));
      end
    end

    // both channels valid together: write, read, write
    awid = 4'd9; awaddr = 32'h900; awlen = 0; awsize = 3; awburst = 1;
    arid = 4'd10; araddr = 32'h100; arlen = 0; arsize = 3; arburst = 1;
    awvalid = 1'b1;
    arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int t;
      t = -1;
      g[k] = 0;
      for (int c = 0; c < 40 && t < 0; c++) begin
        @(negedge clk);
        if (awready) begin t = cyc; g[k] = 1; end
        else if (arready) begin t = cyc; g[k] = 2; end
        @(posedge clk); #1;
      end
      if (t < 0) tmo("arb_grant");
      if (g[k] == 1) begin
        awvalid = 1'b0;
        w_send(8'd0, 64'h9000 + 64'(k), 8'hFF, 0, tf, tl);
        b_recv(br, bi, tb);
        chk("arb_bresp", br, 2'd0);
        awvalid = (k < 2);
      end else if (g[k] == 2) begin
        arvalid = 1'b0;
        r_recv(4'b1111, 0);
        chk("arb_rdata", rd_data[0], 64'h00000000_CAFEF00D);
        arvalid = 1'b1;
      end
    end
    arvalid = 1'b0;
    awvalid = 1'b0;
    chk("arb_grant0", g[0], 1);
    chk("arb_grant1", g[1], 2);
    chk("arb_grant2", g[2], 1);

    // WRAP address sequence
    wr_addrs.delete();
    aw_send(4'd1, 32'h318, 8'd3, 3'd3, 2'd2, ta);
    w_send(8'd3, 64'h3000, 8'hFF, 3, tf, tl);
    b_recv(br, bi, tb);
    chk("wrap_n_writes", wr_addrs.size(), 4);
    if (wr_addrs.size() == 4) begin
      chk("wrap_addr0", wr_addrs[0], 27'h63);
      chk("wrap_addr1", wr_addrs[1], 27'h60);
      chk("wrap_addr2", wr_addrs[2], 27'h61);
      chk("wrap_addr3", wr_addrs[3], 27'h62);
    end
    ar_send(4'd2, 32'h300, 8'd3, 3'd3, 2'd1, ta);
    r_recv(4'b1111, 0);
    chk("wrap_rd_beats", nrd, 4);
    chk("wrap_rd0", rd_data[0], 64'h3001);
    chk("wrap_rd1", rd_data[1], 64'h3002);
    chk("wrap_rd2", rd_data[2], 64'h3003);
    chk("wrap_rd3", rd_data[3], 64'h3000);

    // WLAST early on beat 1 of a 4-beat burst
    aw_send(4'd3, 32'hA00, 8'd3, 3'd3, 2'd1, ta);
    w_send(8'd3, 64'hA000, 8'hFF, 1, tf, tl);
    chk("wlast_beats", tl - tf, 3);
    b_recv(br, bi, tb);
    chk("wlast_b_cycle", tb, tl + 1);
    chk("wlast_bresp", br, 2'd2);

    // RREADY held low: issue stops once FIFO plus pipe are full
    ar_send(4'd4, 32'h200, 8'd7, 3'd3, 2'd1, ta);
    base = rd_issues;
    rready = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("stall_issued", rd_issues - base, LAT + 2);
    chk("stall_rvalid", rvalid, 1);
    r_recv(4'b1111, 0);
    chk("stall_beats", nrd, 8);
    for (int n = 0; n < nrd; n++)
      chk($sformatf("stall_rdata%0d", n), rd_data[n],
          64'h1000_0000_0000_0000 + 64'(n));

    // reset during beat 3 of an 8-beat read
    ar_send(4'd5, 32'h200, 8'd7, 3'd3, 2'd1, ta);
    rready = 1'b1;
    base = 0;
    for (int k = 0; k < 40 && base < 2; k++) begin
      @(negedge clk);
      if (rvalid) base++;
      @(posedge clk); #1;
    end
    if (base < 2) tmo("reset_beats");
    rstn = 1'b0;
    #1;
    chk("arst_rvalid", rvalid, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_rlast", rlast, 0);
    chk("arst_cen", cen, 1);
    chk("arst_wen", wen, 1);
    chk("arst_arready", arready, 0);
    rready = 1'b0;
    @(posedge clk); #1;
    chk("arst_cen_held", cen, 1);
    rstn = 1'b1;
    @(posedge clk); #1;
    ar_send(4'd6, 32'h100, 8'd0, 3'd3, 2'd1, ta);
    r_recv(4'b1111, 0);
    chk("post_rst_beats", nrd, 1);
    chk("post_rst_rdata", rd_data[0], 64'h00000000_CAFEF00D);
    chk("post_rst_rid", rd_id[0], 4'd6);
    chk("post_rst_first_read", first_rd, ta + 1);
    chk("post_rst_first_rvalid", first_rv, ta + 2 + LAT);

    chk("max_outstanding_ok", max_out <= LAT + 2, 1);
    chk("b_r_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
